// File: rtl/matrix_tx_arbiter.sv
// Round-robin owner of the shared matrix-buffer + UART-send path: latches the winner's selector,
// sequences burst load / send, and pulses done to the winner. Optional watchdog: MATRIX_TX_TIMEOUT_EN.
module matrix_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int SEL_IDX_W   = 2,
  parameter int TIMEOUT_CYC = 100000000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ*(6+SEL_IDX_W)-1:0]     req_sel,
  input  logic                                 buf_full,
  input  logic                                 send_done,
  output logic [NUM_REQ-1:0]                   grant,
  output logic [NUM_REQ-1:0]                   done,
  output logic [2:0]                           sel_row,
  output logic [2:0]                           sel_col,
  output logic [SEL_IDX_W-1:0]                 sel_idx,
  output logic                                 matrix_burst_en,
  output logic                                 send_trig,
  output logic                                 busy,
  output logic                                 err_timeout
);

  localparam int SW = 6 + SEL_IDX_W;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("matrix_tx_arbiter: NUM_REQ and TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, BURST, WAIT_BUF, SEND, WAIT_DONE, RELEASE} state_t;

  state_t              state, state_next;
  logic [PW-1:0]       rr_ptr, owner, winner;
  logic                winner_vld;
  logic [SW-1:0]       sel_q;
  logic [2*NUM_REQ-1:0] req_rot;
  int unsigned         win_off;
  logic                wd_expired;

  // Rotate requests so bit 0 is the rr_ptr position; first set bit is the winner offset.
  always_comb begin
    req_rot    = {req, req} >> rr_ptr;
    win_off    = 0;
    winner_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!winner_vld && req_rot[k]) begin
        winner_vld = 1'b1;
        win_off    = k;
      end
    end
    winner = PW'((32'(rr_ptr) + win_off) % NUM_REQ);
  end

`ifdef MATRIX_TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] wd_cnt;
  logic          to_flag;

  always_ff @(posedge clk) begin
    if (rst || state_next != state) wd_cnt <= '0;
    else if (state == WAIT_BUF || state == WAIT_DONE) wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_expired = (wd_cnt == TW'(TIMEOUT_CYC - 1));

  // Set only on the edge into RELEASE that was not caused by a real send_done.
  always_ff @(posedge clk) begin
    if (rst) to_flag <= 1'b0;
    else     to_flag <= (state_next == RELEASE) && !(state == WAIT_DONE && send_done);
  end

  assign err_timeout = to_flag && (state == RELEASE);
`else
  assign wd_expired  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (winner_vld) state_next = BURST;
      BURST:     state_next = WAIT_BUF;
      WAIT_BUF:  if (buf_full) state_next = SEND;
                 else if (wd_expired) state_next = RELEASE;
      SEND:      state_next = WAIT_DONE;
      WAIT_DONE: if (send_done || wd_expired) state_next = RELEASE;
      RELEASE:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      owner  <= '0;
      sel_q  <= '0;
    end else begin
      if (state == IDLE && winner_vld) begin
        owner <= winner;
        sel_q <= req_sel[winner*SW +: SW];
      end
      if (state == RELEASE) rr_ptr <= PW'((32'(owner) + 1) % NUM_REQ);
    end
  end

  always_comb begin
    grant           = '0;
    done            = '0;
    matrix_burst_en = (state == BURST);
    send_trig       = (state == SEND);
    busy            = (state != IDLE);
    if (state == BURST || state == WAIT_BUF || state == SEND || state == WAIT_DONE)
      grant = NUM_REQ'(1) << owner;
    if (state == RELEASE)
      done = NUM_REQ'(1) << owner;
  end

  assign sel_row = sel_q[SW-1 -: 3];
  assign sel_col = sel_q[SEL_IDX_W+2 -: 3];
  assign sel_idx = sel_q[SEL_IDX_W-1:0];

endmodule

// File: tb/tb_matrix_tx_arbiter.sv
// Randomized self-checking bench for matrix_tx_arbiter against a transaction-level model.
module tb_matrix_tx_arbiter;

  localparam int N  = 3;
  localparam int IW = 2;
  localparam int SW = 6 + IW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*SW-1:0] req_sel;
  logic            buf_full, send_done;
  logic [N-1:0]    grant, done;
  logic [2:0]      sel_row, sel_col;
  logic [IW-1:0]   sel_idx;
  logic            matrix_burst_en, send_trig, busy, err_timeout;

  matrix_tx_arbiter #(.NUM_REQ(N), .SEL_IDX_W(IW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_sel(req_sel),
    .buf_full(buf_full), .send_done(send_done),
    .grant(grant), .done(done), .sel_row(sel_row), .sel_col(sel_col), .sel_idx(sel_idx),
    .matrix_burst_en(matrix_burst_en), .send_trig(send_trig), .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: round-robin pointer and last latched selector.
  int          rr_m;
  logic [SW-1:0] sel_m;

  logic [17:0] obs, exp_v;
  assign obs = {grant, done, sel_row, sel_col, sel_idx, matrix_burst_en, send_trig, busy, err_timeout};

  function automatic int arb(input logic [N-1:0] r, input int rr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Starts in an IDLE cycle; ends in the IDLE cycle after RELEASE.
  task automatic run_transfer(input logic [N-1:0] r, input logic [N*SW-1:0] sels, input int bd,
                              input int dd, input int drop_at, input bit noise, input string name);
    int w, rel;
    logic [N-1:0] oh;
    w = arb(r, rr_m);
    n_tests++;
    exp_v = {6'b0, sel_m, 4'b0010 & 4'b0000};
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s idle-before: got %b want %b", name, obs, exp_v);
    end
    req = r; req_sel = sels;
    step();
    sel_m = sels[w*SW +: SW];
    oh    = N'(1) << w;
    rel   = 4 + bd + dd;
    for (int c = 0; c <= rel; c++) begin
      exp_v = {(c < rel) ? oh : 3'b000, (c == rel) ? oh : 3'b000, sel_m,
               (c == 0), (c == 2 + bd), 1'b1, 1'b0};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %b want %b", name, c, obs, exp_v);
      end
      buf_full  = (c >= 1 + bd && c < 3 + bd) || (noise && c == 0);
      send_done = (c == 3 + bd + dd) || (noise && c <= 2 + bd);
      if (c == drop_at) begin
        req = '0; req_sel = (N*SW)'($urandom);
      end else if (noise) begin
        req = N'($urandom); req_sel = (N*SW)'($urandom);
      end
      step();
    end
    rr_m = (w + 1) % N;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_sel = '0; buf_full = 1'b0; send_done = 1'b0;
    step(); step();
    n_tests++;
    if (obs !== 18'd0) begin n_fail++; $display("FAIL reset: got %b want 0", obs); end
    rst = 1'b0;
    step();
    n_tests++;
    if (obs !== 18'd0) begin n_fail++; $display("FAIL reset_idle: got %b want 0", obs); end
    rr_m = 0; sel_m = '0;
  endtask

  task automatic test_basic();
    run_transfer(3'b001, {16'h0, 3'd3, 3'd2, 2'd1}, 2, 9, -1, 1'b0, "basic");
    req = '0;
    step();
    n_tests++;
    exp_v = {6'b0, 3'd3, 3'd2, 2'd1, 4'b0};
    if (obs !== exp_v) begin n_fail++; $display("FAIL basic_after: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_rr_all();
    for (int i = 0; i < 4; i++)
      run_transfer(3'b111, (N*SW)'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1, 1'b0, "rr_all");
  endtask

  task automatic test_rr_skip();
    run_transfer(3'b010, (N*SW)'($urandom), 0, 0, -1, 1'b0, "rr_skip_a");
    run_transfer(3'b011, (N*SW)'($urandom), 1, 0, -1, 1'b0, "rr_skip_b");
    n_tests++;
    if (rr_m !== 1) begin n_fail++; $display("FAIL rr_skip_owner: got next_ptr %0d want 1", rr_m); end
  endtask

  task automatic test_drop();
    run_transfer(3'b001, (N*SW)'($urandom), 1, 5, 6, 1'b0, "drop");
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      exp_v = {6'b0, sel_m, 4'b0};
      if (obs !== exp_v) begin n_fail++; $display("FAIL drop_idle: got %b want %b", obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    run_transfer(3'b010, (N*SW)'($urandom), 0, 0, -1, 1'b0, "pre_rst");
    req = 3'b100; req_sel = (N*SW)'($urandom);
    sel_m = req_sel[2*SW +: SW];
    step();
    req = '0; buf_full = 1'b1;
    step();
    buf_full = 1'b0;
    step(); step();
    n_tests++;
    exp_v = {3'b100, 3'b000, sel_m, 4'b0010};
    if (obs !== exp_v) begin n_fail++; $display("FAIL rst_mid_wait: got %b want %b", obs, exp_v); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (obs !== 18'd0) begin n_fail++; $display("FAIL rst_mid: got %b want 0", obs); end
    send_done = 1'b1;
    step();
    send_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (obs !== 18'd0) begin n_fail++; $display("FAIL rst_mid_nodone: got %b want 0", obs); end
      step();
    end
    rr_m = 0; sel_m = '0;
    run_transfer(3'b111, (N*SW)'($urandom), 0, 1, -1, 1'b0, "post_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      logic [N-1:0] r;
      r = N'($urandom_range(1, 7));
      run_transfer(r, (N*SW)'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 12), 1'($urandom), "random");
    end
  endtask

`ifdef MATRIX_TX_TIMEOUT_EN
  task automatic test_timeout();
    logic [N-1:0] oh;
    int w;
    req = 3'b111; req_sel = (N*SW)'($urandom);
    w = arb(req, rr_m);
    oh = N'(1) << w;
    step();
    sel_m = req_sel[w*SW +: SW];
    req = '0; buf_full = 1'b0; send_done = 1'b0;
    for (int c = 0; c <= 17; c++) begin
      exp_v = {(c < 17) ? oh : 3'b000, (c == 17) ? oh : 3'b000, sel_m,
               (c == 0), 1'b0, 1'b1, (c == 17)};
      n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL timeout cyc %0d: got %b want %b", c, obs, exp_v); end
      step();
    end
    n_tests++;
    exp_v = {6'b0, sel_m, 4'b0};
    if (obs !== exp_v) begin n_fail++; $display("FAIL timeout_idle: got %b want %b", obs, exp_v); end
    rr_m = (w + 1) % N;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_basic();
    test_rr_all();
    test_rr_skip();
    test_drop();
    test_reset_mid();
`ifdef MATRIX_TX_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    req = '0;
    step();
    n_tests++;
    exp_v = {6'b0, sel_m, 4'b0};
    if (obs !== exp_v) begin n_fail++; $display("FAIL final_idle: got %b want %b", obs, exp_v); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
